// File: rtl/serial_cmp_pkg.sv
// Shared types for the framed serial comparator: digit verdicts, FSM state,
// and the verdict-to-flag mapping used for both the running and result flags.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_LT = 2'd1,
    CMP_GT = 2'd2
  } cmp_verdict_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } cmp_state_t;

  // Returns {less, eq, greater}; exactly one bit is ever set.
  function automatic logic [2:0] verdict_flags(input cmp_verdict_t v);
    case (v)
      CMP_LT:  return 3'b100;
      CMP_GT:  return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

endpackage

// File: rtl/serial_cmp_digit.sv
// Combinational compare of one digit pair. signed_en selects a two's-complement
// interpretation, used only for the most-significant digit of an operand.
module serial_cmp_digit
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               signed_en,
  output cmp_verdict_t       verdict
);

  logic a_lt;
  logic a_gt;

  // Pick the signed or unsigned ordering, then fold into a verdict.
  always_comb begin
    a_lt    = 1'b0;
    a_gt    = 1'b0;
    verdict = CMP_EQ;
    if (signed_en) begin
      a_lt = $signed(a) < $signed(b);
      a_gt = $signed(a) > $signed(b);
    end else begin
      a_lt = a < b;
      a_gt = a > b;
    end
    if (a_lt)      verdict = CMP_LT;
    else if (a_gt) verdict = CMP_GT;
  end

endmodule

// File: rtl/serial_comparator_framed.sv
// Framed bit/digit-serial magnitude comparator. Digits of two operands arrive
// one pair per accepted cycle, MSB-first or LSB-first; one verdict per frame
// is presented on the result port.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Input side: in_valid/in_ready, in_ready = !res_valid. Result
// side: res_valid/res_ready; res_* stay stable while res_valid is high and
// are held afterwards until the next result overwrites them.
module serial_comparator_framed
  import serial_cmp_pkg::*;
#(
  parameter int  DIGIT_W    = 1,
  parameter int  MAX_DIGITS = 16,
  parameter bit  SIGNED     = 1'b0,
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               msb_first,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               run_less,
  output logic               run_eq,
  output logic               run_greater,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_less,
  output logic               res_eq,
  output logic               res_greater,
  output logic               res_err,
  output logic [CNT_W-1:0]   res_digits,
  output logic [1:0]         dbg_state
);

  cmp_state_t   state_q, state_d;
  cmp_verdict_t run_q, res_q, digit_v, base_v, merged_v;
  logic         msb_q, res_err_q;
  logic [CNT_W-1:0] cnt_q, res_cnt_q, cnt_next;
  logic         accept, opening, msb_cur, frame_end, sign_digit;

  assign in_ready  = (state_q != ST_DONE);
  assign res_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign opening   = (state_q == ST_IDLE);
  assign dbg_state = state_q;

  serial_cmp_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .a         (a),
    .b         (b),
    .signed_en (sign_digit),
    .verdict   (digit_v)
  );

  // Per-digit bookkeeping: mode, count, end-of-frame, sign position, merge.
  always_comb begin
    msb_cur    = opening ? msb_first : msb_q;
    cnt_next   = opening ? CNT_W'(1) : cnt_q + CNT_W'(1);
    frame_end  = in_last || (cnt_next == CNT_W'(MAX_DIGITS));
    // The sign lives in the first digit MSB-first, in the last one LSB-first.
    sign_digit = SIGNED && (msb_cur ? opening : frame_end);
    // A new frame starts from EQ regardless of the held verdict.
    base_v     = opening ? CMP_EQ : run_q;
    merged_v   = base_v;
    if (msb_cur) begin
      if (base_v == CMP_EQ) merged_v = digit_v;
    end else begin
      if (digit_v != CMP_EQ) merged_v = digit_v;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: open/extend a frame on accepted digits, release on result take.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACTIVE: if (accept) state_d = frame_end ? ST_DONE : ST_ACTIVE;
      ST_DONE:            if (res_ready) state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  // Running verdict, count, latched mode, and the captured frame result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= CMP_EQ;
      cnt_q     <= '0;
      msb_q     <= 1'b1;
      res_q     <= CMP_EQ;
      res_err_q <= 1'b0;
      res_cnt_q <= '0;
    end else if (accept) begin
      run_q <= merged_v;
      cnt_q <= cnt_next;
      if (opening) msb_q <= msb_first;
      if (frame_end) begin
        res_q     <= merged_v;
        res_err_q <= !in_last;
        res_cnt_q <= cnt_next;
      end
    end
  end

  assign {run_less, run_eq, run_greater} = verdict_flags(run_q);
  assign {res_less, res_eq, res_greater} = verdict_flags(res_q);
  assign res_err    = res_err_q;
  assign res_digits = res_cnt_q;

endmodule
